// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate unit: operation encodings and FSM states.
package shift_pkg;

    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_LSH = 2'b01;
    localparam logic [1:0] MODE_ASH = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step. All bit steering for the unit lives here.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);

    // Arithmetic left is the same as logical left; the reserved mode falls back to rotate.
    always_comb begin
        y = x;
        if (dir == DIR_LEFT) begin
            if (mode == MODE_LSH || mode == MODE_ASH) begin
                y = {x[WIDTH-2:0], 1'b0};
            end else begin
                y = {x[WIDTH-2:0], x[WIDTH-1]};
            end
        end else begin
            case (mode)
                MODE_LSH: y = {1'b0, x[WIDTH-1:1]};
                MODE_ASH: y = {x[WIDTH-1], x[WIDTH-1:1]};
                default:  y = {x[0], x[WIDTH-1:1]};
            endcase
        end
    end

endmodule

// File: rtl/seq_shift_rotate_unit.sv
// Iterative shifter/rotator: loads a word, then applies one single-bit step per clock
// until the latched amount is exhausted, with a start/busy/done handshake.
module seq_shift_rotate_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_eff;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] step_out;
    logic             accept;

    // Only reachable for non-power-of-two widths, where amt can exceed WIDTH-1.
    assign amt_eff = (amt > AMT_MAX) ? AMT_MAX : amt;
    assign accept  = start && (state == IDLE || state == DONE);
    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .x    (dout),
        .dir  (dir_q),
        .mode (mode_q),
        .y    (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    next_state = (amt_eff != '0) ? SHIFT : DONE;
                end else begin
                    next_state = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == AMT_W'(1)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operation parameters are captured once at acceptance so later input changes are inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= '0;
            cnt    <= '0;
            dir_q  <= DIR_LEFT;
            mode_q <= MODE_ROT;
        end else if (accept) begin
            dout   <= din;
            cnt    <= amt_eff;
            dir_q  <= dir;
            mode_q <= mode;
        end else if (state == SHIFT) begin
            dout <= step_out;
            cnt  <= cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
// Scoreboard bench for seq_shift_rotate_unit at widths 4, 8 and 5 with directed vectors.
module tb_seq_shift_rotate_unit;

    typedef struct {
        logic [7:0] dout;
        int         cyc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    item_t q4[$];
    item_t q8[$];
    item_t q5[$];

    logic       start4 = 0, dir4 = 0, busy4, done4;
    logic [3:0] din4 = 0, dout4;
    logic [1:0] amt4 = 0, mode4 = 0;

    logic       start8 = 0, dir8 = 0, busy8, done8;
    logic [7:0] din8 = 0, dout8;
    logic [2:0] amt8 = 0;
    logic [1:0] mode8 = 0;

    logic       start5 = 0, dir5 = 0, busy5, done5;
    logic [4:0] din5 = 0, dout5;
    logic [2:0] amt5 = 0;
    logic [1:0] mode5 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_rotate_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .din(din4), .amt(amt4), .dir(dir4),
        .mode(mode4), .busy(busy4), .done(done4), .dout(dout4));

    seq_shift_rotate_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .din(din8), .amt(amt8), .dir(dir8),
        .mode(mode8), .busy(busy8), .done(done8), .dout(dout8));

    seq_shift_rotate_unit #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .din(din5), .amt(amt5), .dir(dir5),
        .mode(mode5), .busy(busy5), .done(done5), .dout(dout5));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, value and timing.
    always @(negedge clk) begin
        item_t it;
        if (done4) begin
            if (q4.size() == 0) check("w4_unexpected_done", 1, 0);
            else begin
                it = q4.pop_front();
                check("w4_dout", int'(dout4), int'(it.dout));
                check("w4_latency", cyc, it.cyc);
            end
        end
        if (done8) begin
            if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
            else begin
                it = q8.pop_front();
                check("w8_dout", int'(dout8), int'(it.dout));
                check("w8_latency", cyc, it.cyc);
            end
        end
        if (done5) begin
            if (q5.size() == 0) check("w5_unexpected_done", 1, 0);
            else begin
                it = q5.pop_front();
                check("w5_dout", int'(dout5), int'(it.dout));
                check("w5_latency", cyc, it.cyc);
            end
        end
    end

    // Issue tasks are called at a negedge; the accepting edge is the next posedge.
    task automatic issue4(input [3:0] d, input [1:0] a, input logic dr, input [1:0] m, input [3:0] e);
        item_t it;
        din4 = d; amt4 = a; dir4 = dr; mode4 = m; start4 = 1'b1;
        it.dout = {4'h0, e}; it.cyc = cyc + 1 + int'(a);
        q4.push_back(it);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issue8(input [7:0] d, input [2:0] a, input logic dr, input [1:0] m, input [7:0] e);
        item_t it;
        din8 = d; amt8 = a; dir8 = dr; mode8 = m; start8 = 1'b1;
        it.dout = e; it.cyc = cyc + 1 + int'(a);
        q8.push_back(it);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue5(input [4:0] d, input [2:0] a, input int lat, input logic dr,
                          input [1:0] m, input [4:0] e);
        item_t it;
        din5 = d; amt5 = a; dir5 = dr; mode5 = m; start5 = 1'b1;
        it.dout = {3'h0, e}; it.cyc = cyc + 1 + lat;
        q5.push_back(it);
        @(negedge clk);
        start5 = 1'b0;
    endtask

    // Waits for all scoreboards to drain, counting busy cycles of the given instance.
    task automatic drain(input string name, input int which, output int busy_cycles);
        int n = 0;
        busy_cycles = 0;
        while ((q4.size() + q8.size() + q5.size()) != 0 && n < 60) begin
            if ((which == 4 && busy4) || (which == 8 && busy8) || (which == 5 && busy5))
                busy_cycles++;
            @(negedge clk);
            n++;
        end
        if (n >= 60) check({name, "_timeout"}, 1, 0);
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        int b;
        logic [3:0] d;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dout8", int'(dout8), 0);
        check("rst_busy8", int'(busy8), 0);
        check("rst_done8", int'(done8), 0);
        check("rst_dout4", int'(dout4), 0);
        rst = 1'b0;
        @(negedge clk);

        // Width 4 rotate left by 1
        issue4(4'b1000, 2'd1, 1'b0, 2'b00, 4'b0001);
        drain("w4_rol1", 4, b);
        check("w4_rol1_busy_cycles", b, 1);
        for (int i = 0; i < 16; i++) begin
            d = 4'(i);
            issue4(d, 2'd1, 1'b0, 2'b00, {d[2:0], d[3]});
            drain("w4_sweep", 4, b);
        end

        // Width 4 rotate right by 2, then amt=0
        issue4(4'b1011, 2'd2, 1'b1, 2'b00, 4'b1110);
        drain("w4_ror2", 4, b);
        check("w4_ror2_busy_cycles", b, 2);
        issue4(4'b0110, 2'd0, 1'b1, 2'b00, 4'b0110);
        drain("w4_amt0", 4, b);
        check("w4_amt0_busy_cycles", b, 0);

        // Width 8 shift modes
        issue8(8'h80, 3'd3, 1'b1, 2'b10, 8'hF0);
        drain("w8_asr3", 8, b);
        check("w8_asr3_busy_cycles", b, 3);
        issue8(8'h80, 3'd3, 1'b1, 2'b01, 8'h10);
        drain("w8_lsr3", 8, b);
        issue8(8'hFF, 3'd4, 1'b0, 2'b01, 8'hF0);
        drain("w8_lsl4", 8, b);
        issue8(8'hC1, 3'd2, 1'b0, 2'b10, 8'h04);
        drain("w8_asl2", 8, b);
        issue8(8'h81, 3'd1, 1'b0, 2'b11, 8'h03);
        drain("w8_reserved", 8, b);

        // Start while busy is ignored; then back-to-back start in the DONE cycle
        issue8(8'h01, 3'd5, 1'b0, 2'b00, 8'h20);
        din8 = 8'hFF; amt8 = 3'd1; dir8 = 1'b1; mode8 = 2'b01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; din8 = 8'h55;
        b = 0;
        while (!done8 && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("w8_done_seen", int'(done8), 1);
        issue8(8'h0F, 3'd4, 1'b1, 2'b00, 8'hF0);
        drain("w8_b2b", 8, b);

        // Reset in the third SHIFT cycle aborts with no done pulse
        din8 = 8'hAA; amt8 = 3'd7; dir8 = 1'b0; mode8 = 2'b00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_abort_busy", int'(busy8), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("w8_abort_dout", int'(dout8), 0);
        check("w8_abort_busy_low", int'(busy8), 0);
        check("w8_abort_done", int'(done8), 0);
        repeat (10) @(negedge clk);
        issue8(8'h96, 3'd2, 1'b1, 2'b00, 8'hA5);
        drain("w8_after_abort", 8, b);

        // Width 5 clamps amt 7 to 4
        issue5(5'b00001, 3'd7, 4, 1'b0, 2'b00, 5'b10000);
        drain("w5_clamp", 5, b);
        check("w5_clamp_busy_cycles", b, 4);
        issue5(5'b00001, 3'd3, 3, 1'b1, 2'b00, 5'b00100);
        drain("w5_ror3", 5, b);
    endtask

    task automatic checkOutput();
        check("q4_empty", q4.size(), 0);
        check("q8_empty", q8.size(), 0);
        check("q5_empty", q5.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        applyStimulus();
        checkOutput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
